// File: rtl/pwm_timebase.sv
// Coarse PWM timebase with double-buffered period/compare settings.
// New settings go into a shadow register and are applied only at a period wrap or while stopped.
module pwm_timebase #(
  parameter int                        WIDTH    = 17,
  parameter int                        HRBITS   = 3,
  parameter logic [WIDTH-HRBITS-2:0]   PER_RST  = '1,
  parameter logic [WIDTH-2:0]          CMPH_RST = '0,
  parameter logic [WIDTH-2:0]          CMPL_RST = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [WIDTH-HRBITS-2:0]      wr_period,
  input  logic [WIDTH-2:0]             wr_cmpH,
  input  logic [WIDTH-2:0]             wr_cmpL,
  output logic [WIDTH-HRBITS-2:0]      tb,
  output logic [WIDTH-2:0]             cmpH,
  output logic [WIDTH-2:0]             cmpL,
  output logic                         tc,
  output logic                         upd,
  output logic                         err,
  input  logic                         err_clr
);

  localparam int TBW = WIDTH - HRBITS - 1;
  localparam int CW  = WIDTH - 1;

  logic [TBW-1:0] per_act;
  logic [TBW-1:0] per_sh;
  logic [CW-1:0]  cmpH_sh;
  logic [CW-1:0]  cmpL_sh;
  logic           pending;

  logic           xfer;
  logic           apply;
  logic           bad_range;
  logic [TBW-1:0] tb_next;

  // The coarse part of each compare must not lie beyond the terminal count.
  function automatic logic range_bad(input logic [CW-1:0] h, input logic [CW-1:0] l,
                                     input logic [TBW-1:0] p);
    return (h[CW-1:HRBITS] > p) || (l[CW-1:HRBITS] > p);
  endfunction

  assign tc        = en && (tb == per_act);
  assign wr_ready  = !pending;
  assign xfer      = wr_valid && !pending;
  assign apply     = pending && (tc || !en);
  assign bad_range = range_bad(wr_cmpH, wr_cmpL, wr_period);

  // Wrap is an equality compare against the terminal count, never a counter overflow.
  always_comb begin
    tb_next = tb + TBW'(1);
    if (!en || (tb == per_act)) begin
      tb_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tb      <= '0;
      per_act <= PER_RST;
      cmpH    <= CMPH_RST;
      cmpL    <= CMPL_RST;
      per_sh  <= PER_RST;
      cmpH_sh <= CMPH_RST;
      cmpL_sh <= CMPL_RST;
      pending <= 1'b0;
      upd     <= 1'b0;
      err     <= 1'b0;
    end else begin
      tb  <= tb_next;
      upd <= 1'b0;
      // xfer needs pending=0 and apply needs pending=1, so they never coincide.
      if (apply) begin
        per_act <= per_sh;
        cmpH    <= cmpH_sh;
        cmpL    <= cmpL_sh;
        pending <= 1'b0;
        upd     <= 1'b1;
      end else if (xfer) begin
        per_sh  <= wr_period;
        cmpH_sh <= wr_cmpH;
        cmpL_sh <= wr_cmpL;
        pending <= 1'b1;
      end
      if (xfer && bad_range) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_timebase.sv
// Directed bench for pwm_timebase: counting, shadowed updates, stall, range error and reset discard.
module tb_pwm_timebase;

  localparam int WIDTH  = 17;
  localparam int HRBITS = 3;
  localparam int TBW    = WIDTH - HRBITS - 1;
  localparam int CW     = WIDTH - 1;

  logic           clk;
  logic           rst;
  logic           en;
  logic           wr_valid;
  logic           wr_ready;
  logic [TBW-1:0] wr_period;
  logic [CW-1:0]  wr_cmpH;
  logic [CW-1:0]  wr_cmpL;
  logic [TBW-1:0] tb;
  logic [CW-1:0]  cmpH;
  logic [CW-1:0]  cmpL;
  logic           tc;
  logic           upd;
  logic           err;
  logic           err_clr;

  int errors = 0;
  int checks = 0;

  pwm_timebase #(
    .WIDTH(WIDTH), .HRBITS(HRBITS), .PER_RST(13'd4), .CMPH_RST(16'h0000), .CMPL_RST(16'h0000)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_period(wr_period), .wr_cmpH(wr_cmpH), .wr_cmpL(wr_cmpL),
    .tb(tb), .cmpH(cmpH), .cmpL(cmpL), .tc(tc), .upd(upd), .err(err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [TBW-1:0] p, input logic [CW-1:0] h, input logic [CW-1:0] l);
    wr_valid  = 1'b1;
    wr_period = p;
    wr_cmpH   = h;
    wr_cmpL   = l;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wr_valid = 1'b0; wr_period = '0;
    wr_cmpH = '0; wr_cmpL = '0; err_clr = 1'b0;
    tick(); tick();
    chk("rst_tb", 32'(tb), 0);
    chk("rst_cmpH", 32'(cmpH), 0);
    chk("rst_cmpL", 32'(cmpL), 0);
    chk("rst_upd", 32'(upd), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ready", 32'(wr_ready), 1);
    chk("rst_tc", 32'(tc), 0);

    // Reset period 4: 0,1,2,3,4,0,...
    rst = 1'b0; en = 1'b1; #1;
    for (int i = 0; i < 12; i++) begin
      chk("cnt_tb", 32'(tb), 32'(i % 5));
      chk("cnt_tc", 32'(tc), 32'((i % 5) == 4));
      tick();
    end

    // Switch to period 9, applied at the tb=4 wrap
    wr(13'd9, 16'h0000, 16'h0000); tick(); wr_valid = 1'b0;
    chk("p9_ready", 32'(wr_ready), 0);
    tick();
    chk("p9_tc", 32'(tc), 1);
    tick();
    chk("p9_tb", 32'(tb), 0);
    chk("p9_upd", 32'(upd), 1);
    chk("p9_ready2", 32'(wr_ready), 1);
    tick();
    chk("p9_upd_end", 32'(upd), 0);
    tick(); tick();
    chk("p9_tb3", 32'(tb), 3);

    // Mid-period write at tb=3 held off until tb=9 wrap
    wr(13'd5, 16'h0010, 16'h0023); tick(); wr_valid = 1'b0;
    chk("mid_ready", 32'(wr_ready), 0);
    chk("mid_cmpH_hold", 32'(cmpH), 0);
    chk("mid_cmpL_hold", 32'(cmpL), 0);
    chk("mid_upd", 32'(upd), 0);
    repeat (5) tick();
    chk("mid_tb9", 32'(tb), 9);
    chk("mid_tc9", 32'(tc), 1);
    chk("mid_cmpH_hold9", 32'(cmpH), 0);
    tick();
    chk("mid_wrap_tb", 32'(tb), 0);
    chk("mid_cmpH", 32'(cmpH), 32'h10);
    chk("mid_cmpL", 32'(cmpL), 32'h23);
    chk("mid_upd1", 32'(upd), 1);
    chk("mid_ready1", 32'(wr_ready), 1);
    chk("mid_err", 32'(err), 0);
    tick();
    chk("mid_upd0", 32'(upd), 0);
    chk("mid_tb1", 32'(tb), 1);
    repeat (4) tick();
    chk("p5_tb5", 32'(tb), 5);
    chk("p5_tc", 32'(tc), 1);

    // Write accepted in tc cycle; second request stalls until first applied
    wr(13'd5, 16'h0008, 16'h0018); tick();
    chk("tcw_tb", 32'(tb), 0);
    chk("tcw_upd", 32'(upd), 0);
    chk("tcw_ready", 32'(wr_ready), 0);
    chk("tcw_cmpH_hold", 32'(cmpH), 32'h10);
    wr(13'd3, 16'h0000, 16'h0000);
    repeat (5) tick();
    chk("tcw_tb5", 32'(tb), 5);
    chk("tcw_stall", 32'(wr_ready), 0);
    chk("tcw_cmpH_hold5", 32'(cmpH), 32'h10);
    tick();
    chk("tcw_apply_cmpH", 32'(cmpH), 32'h08);
    chk("tcw_apply_cmpL", 32'(cmpL), 32'h18);
    chk("tcw_apply_upd", 32'(upd), 1);
    chk("tcw_apply_ready", 32'(wr_ready), 1);
    tick(); wr_valid = 1'b0;
    chk("second_acc_ready", 32'(wr_ready), 0);
    chk("second_upd0", 32'(upd), 0);
    chk("second_cmpH_hold", 32'(cmpH), 32'h08);
    repeat (4) tick();
    chk("second_tc", 32'(tc), 1);
    tick();
    chk("second_tb", 32'(tb), 0);
    chk("second_upd", 32'(upd), 1);
    chk("second_cmpH", 32'(cmpH), 0);
    repeat (3) tick();
    chk("p3_tb", 32'(tb), 3);
    chk("p3_tc", 32'(tc), 1);
    tick(); tick();
    chk("p3_tb1", 32'(tb), 1);

    // Stop mid-period, then write while stopped
    en = 1'b0; #1;
    chk("stop_tc", 32'(tc), 0);
    tick();
    chk("stop_tb", 32'(tb), 0);
    wr(13'd7, 16'h0038, 16'h0001); tick(); wr_valid = 1'b0;
    chk("stopw_ready", 32'(wr_ready), 0);
    chk("stopw_upd0", 32'(upd), 0);
    tick();
    chk("stopw_upd", 32'(upd), 1);
    chk("stopw_cmpH", 32'(cmpH), 32'h38);
    chk("stopw_cmpL", 32'(cmpL), 32'h01);
    chk("stopw_tb", 32'(tb), 0);
    tick();
    chk("stopw_upd_end", 32'(upd), 0);
    en = 1'b1;
    repeat (7) tick();
    chk("p7_tb", 32'(tb), 7);
    chk("p7_tc", 32'(tc), 1);
    tick();
    chk("p7_wrap", 32'(tb), 0);

    // Range error, clear, and set-over-clear priority
    en = 1'b0; tick();
    wr(13'd5, 16'h0000, 16'h0030); tick(); wr_valid = 1'b0;
    chk("rng_err", 32'(err), 1);
    chk("rng_accept", 32'(wr_ready), 0);
    tick();
    chk("rng_upd", 32'(upd), 1);
    chk("rng_cmpL", 32'(cmpL), 32'h30);
    chk("rng_err_sticky", 32'(err), 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("rng_clr", 32'(err), 0);
    err_clr = 1'b1; wr(13'd0, 16'h0008, 16'h0000); tick();
    err_clr = 1'b0; wr_valid = 1'b0;
    chk("rng_prio", 32'(err), 1);
    tick();
    chk("p0_upd", 32'(upd), 1);
    chk("p0_cmpH", 32'(cmpH), 32'h08);
    en = 1'b1; #1;
    chk("p0_tc_a", 32'(tc), 1);
    tick();
    chk("p0_tb", 32'(tb), 0);
    chk("p0_tc_b", 32'(tc), 1);
    chk("p0_err", 32'(err), 1);

    // Reset with a pending shadow at tb=2
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    wr(13'd5, 16'h0008, 16'h0008); tick(); wr_valid = 1'b0;
    tick();
    chk("pre_upd", 32'(upd), 1);
    tick();
    wr(13'd2, 16'h0010, 16'h0010); tick(); wr_valid = 1'b0;
    chk("pre_tb2", 32'(tb), 2);
    chk("pre_pending", 32'(wr_ready), 0);
    rst = 1'b1; #1;
    chk("arst_tb", 32'(tb), 0);
    chk("arst_cmpH", 32'(cmpH), 0);
    chk("arst_cmpL", 32'(cmpL), 0);
    chk("arst_ready", 32'(wr_ready), 1);
    chk("arst_upd", 32'(upd), 0);
    chk("arst_err", 32'(err), 0);
    tick();
    rst = 1'b0; #1;
    for (int i = 0; i < 10; i++) begin
      chk("post_tb", 32'(tb), 32'(i % 5));
      chk("post_tc", 32'(tc), 32'((i % 5) == 4));
      chk("post_upd", 32'(upd), 0);
      tick();
    end
    chk("post_cmpH", 32'(cmpH), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_timebase.md
PWM_TIMEBASE -- requirements
Module: pwm_timebase

Interface
REQ-001 Parameters SHALL be: WIDTH, default 17, full PWM resolution in bits; HRBITS, default 3, high-resolution fine bits; PER_RST, default all-ones, reset period; CMPH_RST, default 0, reset cmpH; CMPL_RST, default 0, reset cmpL.
REQ-002 Derived widths SHALL be TBW = WIDTH-HRBITS-1 and CW = WIDTH-1.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 The ports SHALL be as follows:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  count enable
- wr_valid  in  1  new-setting request
- wr_ready  out  1  block can accept a request
- wr_period  in  TBW  requested terminal count
- wr_cmpH  in  CW  requested set compare
- wr_cmpL  in  CW  requested clear compare
- tb  out  TBW  coarse timebase to the compare stage
- cmpH  out  CW  active set compare
- cmpL  out  CW  active clear compare
- tc  out  1  terminal-count flag
- upd  out  1  update-applied pulse
- err  out  1  sticky range error
- err_clr  in  1  clears err

Function
REQ-005 State SHALL be tb, per_act, cmpH, cmpL, shadow {per_sh, cmpH_sh, cmpL_sh}, pending, upd and err; all outputs SHALL be register-driven except wr_ready and tc.
REQ-006 With en=1, tb SHALL increment by 1 each cycle while tb<per_act, and SHALL load 0 in the cycle after tb==per_act.
REQ-007 The wrap SHALL NOT use arithmetic overflow; tb==per_act is the only wrap condition.
REQ-008 With en=0, tb SHALL be loaded with 0 on the next edge and held there.
REQ-009 tc SHALL equal (en && tb==per_act), combinationally.
REQ-010 wr_ready SHALL equal !pending.
REQ-011 A transfer SHALL occur on an edge where wr_valid && wr_ready; it loads the shadow from wr_* and sets pending=1.
REQ-012 wr_* SHALL be ignored when no transfer occurs.
REQ-013 Apply event = pending && (tc || !en). On an apply event, the next edge SHALL load per_act/cmpH/cmpL from the shadow, clear pending and set upd=1 for exactly one cycle.
REQ-014 Updates SHALL therefore take effect only at a period boundary (tb returning to 0) or while stopped, never mid-period.
REQ-015 A transfer SHALL NOT be applied in the same cycle it is accepted, because pending was 0 in that cycle.
REQ-016 A transfer coinciding with tc SHALL be applied at the following wrap.
REQ-017 Apply latency SHALL be 1 cycle after acceptance when en=0, and at the next wrap when en=1.
REQ-018 wr_period=0 SHALL be legal: tb stays 0 and tc is asserted every enabled cycle.
REQ-019 Range check on transfer: if wr_cmpH[CW-1:HRBITS] > wr_period or wr_cmpL[CW-1:HRBITS] > wr_period, the transfer SHALL still be accepted and err SHALL be set to 1.
REQ-020 err_clr=1 SHALL clear err on the next edge; a simultaneous new range error SHALL take priority and set err to 1.
REQ-021 Deasserting en mid-period SHALL clear tb on the next edge; if pending=1, the same edge SHALL perform the apply event.

Reset
REQ-022 While rst=1, the block SHALL hold tb=0, per_act=PER_RST, cmpH=CMPH_RST, cmpL=CMPL_RST, shadow=same values, pending=0, upd=0 and err=0; wr_ready reads 1.
REQ-023 A rst asserted mid-operation SHALL discard any pending shadow, and no upd pulse SHALL follow release.
REQ-024 The first edge after rst release with en=1 SHALL move tb 0->1.

Verification
REQ-025 Reset, then PER_RST=4 with en=1 for 12 cycles -> tb sequence 0,1,2,3,4,0,1,...; tc high exactly when tb=4.
REQ-026 Period=9 running, write {period=5, cmpH=0x0010, cmpL=0x0023} at tb=3 -> wr_ready=0 next cycle; cmpH/cmpL/per_act stay unchanged until the tb=9 edge; then tb=0, new values active, upd high for 1 cycle, wr_ready=1.
REQ-027 en=0, write {period=7} -> per_act=7 and upd=1 one cycle after acceptance; tb stays 0.
REQ-028 Write accepted in the tc cycle, then a second wr_valid held high -> the second request is stalled (wr_ready=0) until the next wrap applies the first.
REQ-029 Write cmpL coarse=6 with period=5 -> transfer accepted and err=1; err_clr pulse -> err=0 next cycle.
REQ-030 Assert rst with pending=1 at tb=2 -> all state returns to reset values; after release no upd pulse occurs and the old shadow is never applied.
